// File: rtl/cic_comb_chain.sv
// cic_comb_chain
// Comb section of a CIC decimator. It runs N cascaded differentiators,
// y[n] = x[n] - x[n-M], with one register per stage. An output register
// then reduces the last comb result to OW bits.
//
// Optional feature: define CIC_COMB_ROUND_EN to round half up before the
// reduction to OW bits, saturating positive overflow to the largest OW-bit
// value. The macro has no effect when OW == DW.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   din      signed DW-bit low-rate sample, qualified by din_vld
//   din_vld  one-cycle strobe for each new sample
//   dout     signed OW-bit filtered output, held between strobes
//   dout_vld one-cycle strobe, aligned with dout
module cic_comb_chain #(
  parameter int DW = 44,
  parameter int OW = 16,
  parameter int N  = 6,
  parameter int M  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic [OW-1:0] dout,
  output logic          dout_vld
);

  // Stage outputs and their qualifiers. These connect stage k-1 to stage k.
  logic [DW-1:0] y_out [N];
  logic          v_out [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    logic [DW-1:0] x;
    logic          v;
    logic [DW-1:0] y_reg;
    logic          vld_reg;
    logic [DW-1:0] dly_reg [M];

    if (gi == 0) begin : g_first
      assign x = din;
      assign v = din_vld;
    end else begin : g_rest
      assign x = y_out[gi-1];
      assign v = v_out[gi-1];
    end

    // The delay line advances only on a valid sample. The delay therefore
    // counts low-rate samples, not clock cycles. The subtraction wraps
    // modulo 2^DW, which the CIC structure relies on.
    always_ff @(posedge clk) begin
      if (rst) begin
        y_reg   <= '0;
        vld_reg <= 1'b0;
        for (int i = 0; i < M; i++) begin
          dly_reg[i] <= '0;
        end
      end else begin
        vld_reg <= v;
        if (v) begin
          y_reg      <= x - dly_reg[M-1];
          dly_reg[0] <= x;
          for (int i = 1; i < M; i++) begin
            dly_reg[i] <= dly_reg[i-1];
          end
        end
      end
    end

    assign y_out[gi] = y_reg;
    assign v_out[gi] = vld_reg;
  end

  logic [DW-1:0] y_last;
  logic          last_vld;
  logic [OW-1:0] out_next;

  assign y_last   = y_out[N-1];
  assign last_vld = v_out[N-1];

  if (OW < DW) begin : g_narrow
`ifdef CIC_COMB_ROUND_EN
    localparam logic [DW:0] HALF = (DW+1)'(1) << (DW - OW - 1);
    logic [DW:0] rnd;
    logic        ovf;
    logic        unused_rnd_lsbs;
    // The sum is sign-extended by one bit. Adding a positive constant can
    // only overflow upward: the sign flips from 0 into bit DW-1.
    assign rnd             = {y_last[DW-1], y_last} + HALF;
    assign ovf             = ~rnd[DW] & rnd[DW-1];
    assign out_next        = ovf ? {1'b0, {(OW-1){1'b1}}} : rnd[DW-1 -: OW];
    assign unused_rnd_lsbs = ^rnd[DW-OW-1:0];
`else
    logic unused_lsbs;
    assign out_next    = y_last[DW-1 -: OW];
    assign unused_lsbs = ^y_last[DW-OW-1:0];
`endif
  end else begin : g_full
    assign out_next = y_last[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= last_vld;
      if (last_vld) begin
        dout <= out_next;
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_chain.sv
// tb_cic_comb_chain
// Five comb chains with different configurations share one stimulus stream.
// Each cycle, every chain's dout and dout_vld are compared with a model.
// The model keeps the sample history since the last reset. It forms each
// output from the closed form sum_j (-1)^j C(N,j) x[n - j*M], then reduces
// that result to OW bits. Directed sequences are also compared with fixed
// tables.
module tb_cic_comb_chain;
  localparam int DW = 44;
  localparam int NI = 5;
`ifdef CIC_COMB_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_vld = 1'b0;

  logic [43:0] d0, d1, d3;
  logic [15:0] d2, d4;
  logic        v0, v1, v2, v3, v4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_comb_chain #(.DW(44), .OW(44), .N(6), .M(1)) u_i0 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dout(d0), .dout_vld(v0));
  cic_comb_chain #(.DW(44), .OW(44), .N(1), .M(2)) u_i1 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dout(d1), .dout_vld(v1));
  cic_comb_chain #(.DW(44), .OW(16), .N(1), .M(1)) u_i2 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dout(d2), .dout_vld(v2));
  cic_comb_chain #(.DW(44), .OW(44), .N(1), .M(1)) u_i3 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dout(d3), .dout_vld(v3));
  cic_comb_chain #(.DW(44), .OW(16), .N(6), .M(2)) u_i4 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dout(d4), .dout_vld(v4));

  function automatic int n_of(int i);
    case (i)
      0: return 6;
      4: return 6;
      default: return 1;
    endcase
  endfunction

  function automatic int m_of(int i);
    return (i == 1 || i == 4) ? 2 : 1;
  endfunction

  function automatic int ow_of(int i);
    return (i == 2 || i == 4) ? 16 : 44;
  endfunction

  function automatic logic [43:0] get_dout(int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return {28'b0, d2};
      3: return d3;
      default: return {28'b0, d4};
    endcase
  endfunction

  function automatic bit get_vld(int i);
    case (i)
      0: return v0;
      1: return v1;
      2: return v2;
      3: return v3;
      default: return v4;
    endcase
  endfunction

  // Model state
  logic [43:0] hist[$];
  bit          pv [NI][10];
  logic [43:0] pd [NI][10];
  logic [43:0] exp_d [NI];
  bit          exp_v [NI];
  logic [43:0] rec [NI][$];

  // Closed-form N-th order M-delay difference over the history since reset.
  function automatic logic [43:0] comb_ref(int n, int m);
    longint acc = 0;
    longint c = 1;
    logic [63:0] t;
    for (int j = 0; j <= n; j++) begin
      int idx = hist.size() - 1 - j * m;
      if (idx >= 0) begin
        if (j % 2 == 1) acc = acc - c * longint'(signed'(hist[idx]));
        else            acc = acc + c * longint'(signed'(hist[idx]));
      end
      c = c * (n - j) / (j + 1);
    end
    t = acc;
    return t[43:0];
  endfunction

  function automatic logic [43:0] to_out(logic [43:0] y, int ow);
    longint r;
    logic [63:0] t;
    int sh;
    if (ow == 44) return y;
    sh = 44 - ow;
    if (ROUND) begin
      r = longint'(signed'(y)) + (longint'(1) << (sh - 1));
      if (r > (longint'(1) << 43) - 1) return 44'h7FFF;
      t = r >>> sh;
    end else begin
      t = longint'(signed'(y)) >>> sh;
    end
    return {28'b0, t[15:0]};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock edge, update the model, then check all chains 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      hist.delete();
      for (int i = 0; i < NI; i++) begin
        exp_d[i] = '0;
        exp_v[i] = 1'b0;
        for (int k = 0; k < 10; k++) begin
          pv[i][k] = 1'b0;
          pd[i][k] = '0;
        end
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        exp_v[i] = pv[i][0];
        if (pv[i][0]) exp_d[i] = pd[i][0];
        for (int k = 0; k < 9; k++) begin
          pv[i][k] = pv[i][k+1];
          pd[i][k] = pd[i][k+1];
        end
        pv[i][9] = 1'b0;
      end
      if (din_vld) begin
        hist.push_back(din);
        if (hist.size() > 32) void'(hist.pop_front());
        for (int i = 0; i < NI; i++) begin
          pv[i][n_of(i)-1] = 1'b1;
          pd[i][n_of(i)-1] = to_out(comb_ref(n_of(i), m_of(i)), ow_of(i));
        end
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("dout_vld[%0d]", i), 64'(get_vld(i)), 64'(exp_v[i]));
      chk($sformatf("dout[%0d]", i), 64'(get_dout(i)), 64'(exp_d[i]));
      if (get_vld(i)) rec[i].push_back(get_dout(i));
    end
  endtask

  task automatic drive(bit r, bit v, logic [43:0] d);
    rst = r;
    din_vld = v;
    din = d;
    step();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < NI; i++) rec[i].delete();
  endtask

  task automatic idle(int cycles);
    for (int k = 0; k < cycles; k++) drive(1'b0, 1'b0, '0);
  endtask

  task automatic cmp_rec(int i, string tag, longint e[$]);
    logic [63:0] t;
    chk({tag, "_count"}, 64'(rec[i].size()), 64'(e.size()));
    for (int k = 0; k < e.size() && k < rec[i].size(); k++) begin
      t = e[k];
      chk($sformatf("%s[%0d]", tag, k), 64'(rec[i][k]), 64'(t[43:0]));
    end
  endtask

  task automatic impulse_run();
    int lat;
    drive(1'b0, 1'b1, 44'd1);
    lat = 1;
    while (!v0 && lat < 20) begin
      drive(1'b0, 1'b0, '0);
      lat++;
    end
    chk("impulse_latency", 64'(lat), 64'(7));
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, '0);
      drive(1'b0, 1'b0, '0);
    end
    idle(10);
  endtask

  initial begin
    longint e[$];

    // Reset state
    do_reset();
    chk("reset_dout0", 64'(d0), 64'(0));
    chk("reset_vld0", 64'(v0), 64'(0));

    // Impulse response, N=6 M=1
    impulse_run();
    e = '{1, -6, 15, -20, 15, -6, 1, 0, 0};
    cmp_rec(0, "impulse", e);

    // Step response
    do_reset();
    for (int k = 0; k < 9; k++) drive(1'b0, 1'b1, 44'd5);
    idle(10);
    e = '{5, -25, 50, -50, 25, -5, 0, 0, 0};
    cmp_rec(0, "step", e);

    // M=2, N=1
    do_reset();
    drive(1'b0, 1'b1, 44'd3);
    drive(1'b0, 1'b1, 44'd7);
    drive(1'b0, 1'b1, 44'd10);
    drive(1'b0, 1'b1, 44'd10);
    idle(6);
    e = '{3, 7, 7, 3};
    cmp_rec(1, "m2", e);

    // Modular wrap: -2^43 after 1
    do_reset();
    drive(1'b0, 1'b1, 44'd1);
    drive(1'b0, 1'b1, 44'h800_0000_0000);
    idle(4);
    e = '{1, 64'h7FF_FFFF_FFFF};
    cmp_rec(3, "wrap", e);

    // Truncation and rounding: half an output LSB, then full scale
    do_reset();
    drive(1'b0, 1'b1, 44'h000_0800_0000);
    idle(4);
    e = '{ROUND ? 1 : 0};
    cmp_rec(2, "half_lsb", e);
    do_reset();
    drive(1'b0, 1'b1, 44'h7FF_FFFF_FFFF);
    idle(4);
    e = '{64'h7FFF};
    cmp_rec(2, "full_scale", e);

    // Mid-stream reset with three samples in flight
    do_reset();
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 44'($urandom) << 12);
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < NI; i++) rec[i].delete();
    idle(12);
    chk("flush_no_vld", 64'(rec[0].size()), 64'(0));
    impulse_run();
    e = '{1, -6, 15, -20, 15, -6, 1, 0, 0};
    cmp_rec(0, "impulse_after_rst", e);

    // Random traffic with gaps and occasional resets, including reset with a strobe
    for (int k = 0; k < 600; k++) begin
      logic [43:0] rd;
      rd = {12'($urandom), 32'($urandom)};
      if ($urandom_range(0, 2) == 0) rd = 44'($signed(12'($urandom)));
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, rd);
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
